mem_readout_ctrl: RTL and testbench

- Downstream stage of the trigger memory write controller. Once all triggers have been captured, it reads the capture RAM back from address 0.
- Total words read = nwrite*ntrigger.
- Streams words to the link/serializer over a valid/ready handshake, with full backpressure support.
- Sits between the capture RAM read port and the output link. On completion it pulses a request to clear the write side.

---
 rtl/mem_readout_ctrl.sv | 150 +++++++++++++++
 tb/tb_mem_readout_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_readout_ctrl.sv
// Capture-RAM readout: streams nwrite*ntrigger words over valid/ready, then pulses done/wr_clear.
// Optional macro READOUT_HEADER_EN prefixes the stream with a {nwrite, ntrigger} header word.
module mem_readout_ctrl #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        nwrite,
    input  logic [7:0]        ntrigger,
    output logic              rd_en,
    output logic [ADDR_W-1:0] raddr,
    input  logic [DATA_W-1:0] rdata,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic              wr_clear
);
    typedef enum logic [1:0] {IDLE, READ, DRAIN, FIN} state_t;

    state_t            state_q, state_d;
    logic [15:0]       total_q, total_d;
    logic [15:0]       issued_q, issued_d;
    logic [ADDR_W-1:0] raddr_q, raddr_d;
    logic              inflight_q, inflight_d;
    logic              inflight_last_q, inflight_last_d;
    logic [DATA_W-1:0] fifo_data_q [2];
    logic [DATA_W-1:0] fifo_data_d [2];
    logic              fifo_last_q [2];
    logic              fifo_last_d [2];
    logic              rd_ptr_q, rd_ptr_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              done_q, done_d;

    logic              start_ok, pop, push, push_last, rd_fire;
    logic [DATA_W-1:0] push_data;
    logic [15:0]       product;
    logic [1:0]        occ_after_pop, occ_sum;

    assign product = 16'(nwrite) * 16'(ntrigger);

    always_comb begin
        state_d         = state_q;
        total_d         = total_q;
        issued_d        = issued_q;
        raddr_d         = raddr_q;
        push            = inflight_q;
        push_data       = rdata;
        push_last       = inflight_last_q;
        pop             = (cnt_q != 2'd0) && out_ready;
        start_ok        = start && (state_q == IDLE) && !done_q;
        // A word popped this cycle frees its slot, so reads can stream at full rate
        occ_after_pop   = cnt_q - {1'b0, pop};
        occ_sum         = occ_after_pop + {1'b0, inflight_q};
        rd_fire         = (state_q == READ) && (issued_q != total_q) &&
                          (cnt_q != 2'd2) && (occ_sum < 2'd2);
        inflight_d      = rd_fire;
        inflight_last_d = rd_fire && (issued_q == total_q - 16'd1);
        done_d          = (state_q == FIN);

        unique case (state_q)
            IDLE: begin
                if (start_ok) begin
                    total_d  = product;
                    issued_d = '0;
                    raddr_d  = '0;
`ifdef READOUT_HEADER_EN
                    push      = 1'b1;
                    push_data = DATA_W'({nwrite, ntrigger});
                    push_last = (product == 16'd0);
                    state_d   = (product == 16'd0) ? DRAIN : READ;
`else
                    state_d   = (product == 16'd0) ? FIN : READ;
`endif
                end
            end
            READ: begin
                if (rd_fire) begin
                    issued_d = issued_q + 16'd1;
                    raddr_d  = raddr_q + ADDR_W'(1);
                    if (issued_q + 16'd1 == total_q) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (cnt_q == 2'd0 && !inflight_q) state_d = FIN;
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        fifo_data_d = fifo_data_q;
        fifo_last_d = fifo_last_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        if (push) begin
            fifo_data_d[wr_ptr_q] = push_data;
            fifo_last_d[wr_ptr_q] = push_last;
            wr_ptr_d              = !wr_ptr_q;
        end
        if (pop) rd_ptr_d = !rd_ptr_q;
        cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            total_q         <= '0;
            issued_q        <= '0;
            raddr_q         <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            fifo_data_q[0]  <= '0;
            fifo_data_q[1]  <= '0;
            fifo_last_q[0]  <= 1'b0;
            fifo_last_q[1]  <= 1'b0;
            rd_ptr_q        <= 1'b0;
            wr_ptr_q        <= 1'b0;
            cnt_q           <= '0;
            done_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            total_q         <= total_d;
            issued_q        <= issued_d;
            raddr_q         <= raddr_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            fifo_data_q     <= fifo_data_d;
            fifo_last_q     <= fifo_last_d;
            rd_ptr_q        <= rd_ptr_d;
            wr_ptr_q        <= wr_ptr_d;
            cnt_q           <= cnt_d;
            done_q          <= done_d;
        end
    end

    assign rd_en     = rd_fire;
    assign raddr     = raddr_q;
    assign out_valid = (cnt_q != 2'd0);
    assign out_data  = out_valid ? fifo_data_q[rd_ptr_q] : '0;
    assign out_last  = out_valid && fifo_last_q[rd_ptr_q];
    // busy stays up through the done cycle so a back-to-back start is not taken early
    assign busy      = (state_q != IDLE) || done_q;
    assign done      = done_q;
    assign wr_clear  = done_q;
endmodule

// File: tb/tb_mem_readout_ctrl.sv
// Scoreboard bench for mem_readout_ctrl: expected stream queued at start, monitor checks accepted words.
module tb_mem_readout_ctrl;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;

    logic              clk = 1'b0;
    logic              rst, start, rd_en, out_valid, out_ready, out_last, busy, done, wr_clear;
    logic [7:0]        nwrite, ntrigger;
    logic [ADDR_W-1:0] raddr;
    logic [DATA_W-1:0] rdata, out_data;

    mem_readout_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst), .start(start), .nwrite(nwrite), .ntrigger(ntrigger),
        .rd_en(rd_en), .raddr(raddr), .rdata(rdata), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .busy(busy), .done(done), .wr_clear(wr_clear)
    );

    always #5 clk = ~clk;

    logic [DATA_W-1:0] mem [0:65535];
    always @(posedge clk) rdata <= rd_en ? mem[raddr] : DATA_W'($urandom);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              last;
    } word_t;

    word_t exp_q[$];
    word_t w;
    int checks = 0, passed = 0;
    int cyc = 0, rmode = 0;
    int cur_total = 0, rd_seen = 0, acc_cnt = 0, done_cnt = 0, done_cyc = -1;
    int first_valid_cyc = -1, tb_occ = 0, start_cyc = 0;
    bit rd_prev = 0, stall_prev = 0;
    logic [DATA_W-1:0] stall_data;
    logic stall_last;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string name, input longint act, input longint req);
        checks++;
        if (ok) passed++;
        else $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    endtask

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (rmode)
                0:       out_ready = 1'b1;
                1:       out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: out_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            tb_occ = 0; rd_prev = 0; stall_prev = 0;
        end else begin
            if (stall_prev) begin
                chk(out_valid == 1'b1, "stall_valid_held", out_valid, 1);
                chk(out_data == stall_data, "stall_data_held", out_data, stall_data);
                chk(out_last == stall_last, "stall_last_held", out_last, stall_last);
            end
            if (rd_en) begin
                chk(tb_occ < 2, "rd_en_fifo_occupancy", tb_occ, 1);
                chk(int'(raddr) == rd_seen, "raddr_sequence", raddr, rd_seen);
                chk(int'(raddr) < cur_total, "raddr_below_total", raddr, cur_total);
                rd_seen++;
            end
            if (out_valid && out_ready) begin
                chk(exp_q.size() != 0, "unexpected_word", exp_q.size(), 1);
                if (exp_q.size() != 0) begin
                    w = exp_q.pop_front();
                    chk(out_data == w.data, "out_data", out_data, w.data);
                    chk(out_last == w.last, "out_last", out_last, w.last);
                end
                acc_cnt++;
            end
            if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (done || wr_clear) begin
                chk(done == wr_clear, "wr_clear_with_done", wr_clear, done);
                chk(exp_q.size() == 0, "done_after_last_word", exp_q.size(), 0);
                done_cnt++;
                done_cyc = cyc;
            end
            stall_prev = out_valid && !out_ready;
            stall_data = out_data;
            stall_last = out_last;
            tb_occ = tb_occ + (rd_prev ? 1 : 0) - ((out_valid && out_ready) ? 1 : 0);
`ifdef READOUT_HEADER_EN
            if (start && !busy) tb_occ++;
`endif
            rd_prev = rd_en;
        end
    end

    task automatic queue_expected(input logic [7:0] nw, input logic [7:0] nt, input bit ramp);
        int total;
        word_t e;
        total = int'(nw) * int'(nt);
        for (int i = 0; i < total; i++) mem[i] = ramp ? DATA_W'(i) : DATA_W'($urandom);
`ifdef READOUT_HEADER_EN
        e.data = DATA_W'({nw, nt});
        e.last = (total == 0);
        exp_q.push_back(e);
`endif
        for (int i = 0; i < total; i++) begin
            e.data = mem[i];
            e.last = (i == total - 1);
            exp_q.push_back(e);
        end
        cur_total = total;
        rd_seen = 0; acc_cnt = 0; done_cnt = 0; done_cyc = -1; first_valid_cyc = -1;
    endtask

    task automatic pulse_start(input logic [7:0] nw, input logic [7:0] nt);
        @(posedge clk); #1;
        nwrite = nw; ntrigger = nt; start = 1'b1; start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0; nwrite = 8'($urandom); ntrigger = 8'($urandom);
        chk(busy == 1'b1, "busy_after_start", busy, 1);
    endtask

    task automatic run_case(input logic [7:0] nw, input logic [7:0] nt, input int rm,
                            input bit mid_start, input bit ramp);
        int total, budget, hdr_lat;
        total = int'(nw) * int'(nt);
`ifdef READOUT_HEADER_EN
        hdr_lat = 1;
`else
        hdr_lat = 0;
`endif
        rmode = rm;
        queue_expected(nw, nt, ramp);
        pulse_start(nw, nt);
        budget = 0;
        while (done_cnt == 0 && budget < 4000) begin
            @(posedge clk); #1;
            budget++;
            start = mid_start && (budget == 6);
        end
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk(done_cnt == 1, "done_pulse_count", done_cnt, 1);
        chk(busy == 1'b0, "busy_low_after_done", busy, 0);
        chk(out_valid == 1'b0, "idle_no_valid", out_valid, 0);
        chk(rd_seen == total, "read_count", rd_seen, total);
        chk(exp_q.size() == 0, "words_outstanding", exp_q.size(), 0);
        if (rm == 0 && total > 0)
            chk(first_valid_cyc - start_cyc == (hdr_lat == 1 ? 1 : 3), "first_valid_latency",
                first_valid_cyc - start_cyc, (hdr_lat == 1 ? 1 : 3));
        if (total == 0 && hdr_lat == 0) begin
            chk(done_cyc - start_cyc == 2, "empty_done_latency", done_cyc - start_cyc, 2);
            chk(first_valid_cyc == -1, "empty_no_valid", first_valid_cyc, -1);
        end
        exp_q.delete();
    endtask

    task automatic reset_mid();
        int budget;
        rmode = 0;
        queue_expected(8'd4, 8'd2, 1'b0);
        pulse_start(8'd4, 8'd2);
        budget = 0;
        while (acc_cnt < 3 && budget < 200) begin
            @(posedge clk); #1;
            budget++;
        end
        chk(acc_cnt >= 3, "reset_reach_three_words", acc_cnt, 3);
        rst = 1'b1;
        done_cnt = 0;
        @(posedge clk); #1;
        chk({rd_en, out_valid, out_last, busy, done, wr_clear} == 6'b0, "reset_mid_flags",
            {rd_en, out_valid, out_last, busy, done, wr_clear}, 0);
        chk(raddr == '0, "reset_mid_raddr", raddr, 0);
        chk(out_data == '0, "reset_mid_out_data", out_data, 0);
        rst = 1'b0;
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
        chk(done_cnt == 0, "no_done_after_reset", done_cnt, 0);
        chk(out_valid == 1'b0, "no_valid_after_reset", out_valid, 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; nwrite = '0; ntrigger = '0;
        repeat (3) @(posedge clk);
        #1;
        chk({rd_en, out_valid, out_last, busy, done, wr_clear} == 6'b0, "reset_flags",
            {rd_en, out_valid, out_last, busy, done, wr_clear}, 0);
        chk(raddr == '0, "reset_raddr", raddr, 0);
        chk(out_data == '0, "reset_out_data", out_data, 0);
        rst = 1'b0;

        run_case(8'd4, 8'd2, 0, 1'b0, 1'b1);
        run_case(8'd4, 8'd2, 1, 1'b0, 1'b1);
        run_case(8'd0, 8'd5, 0, 1'b0, 1'b0);
        run_case(8'd3, 8'd3, 0, 1'b1, 1'b0);
        reset_mid();
        run_case(8'd4, 8'd2, 0, 1'b0, 1'b1);
        run_case(8'd2, 8'd1, 0, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++)
            run_case(8'($urandom_range(0, 12)), 8'($urandom_range(0, 6)), 2, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
